// File: rtl/rf_scoreboard_pkg.sv
// Shared sizing and types for the register-file write scoreboard.
// Counters track in-flight writers per architectural register.
package rf_scoreboard_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;

  localparam sb_cnt_t CNT_MAX = '1;

endpackage

// File: rtl/rf_scoreboard_sb_counter.sv
// One saturating up/down/clear pending-writer counter.
// Simultaneous inc and dec cancel out.
module sb_counter
  import rf_scoreboard_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clear,
  input  logic    inc,
  input  logic    dec,
  output sb_cnt_t cnt
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  a_no_underflow: assert property (
    @(posedge clk) disable iff (reset || clear)
    (dec && !inc) |-> (cnt != '0));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset || clear)
    (inc && !dec) |-> (cnt != CNT_MAX));

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file RAW scoreboard replacing the ID-stage
// address-compare interlock with per-register counters.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_fire,
  input  logic                issue_we,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic                src1_valid,
  input  logic [ADDR_W-1:0]   src1_addr,
  input  logic                src2_valid,
  input  logic [ADDR_W-1:0]   src2_addr,
  input  logic                dest_check,
  input  logic                retire_fire,
  input  logic                retire_we,
  input  logic [ADDR_W-1:0]   retire_dest,
  input  logic                flush,
  output logic                id_ready_go,
  output logic                src1_hazard,
  output logic                src2_hazard,
  output logic [NUM_REGS-1:0] pending_vec,
  output logic [CNT_W-1:0]    inflight_cnt
);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            inc_vec;
  logic [NUM_REGS-1:0]            dec_vec;
  logic                           iss_ev;
  logic                           ret_ev;
  logic                           dest_sat;

  assign iss_ev = issue_fire && issue_we;
  assign ret_ev = retire_fire && retire_we;

  assign cnt[0]         = '0;
  assign inc_vec[0]     = 1'b0;
  assign dec_vec[0]     = 1'b0;
  assign pending_vec[0] = 1'b0;

  // r0 is hardwired zero, so only 1..31 get a counter
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    assign inc_vec[i] = iss_ev && (issue_dest == ADDR_W'(i));
    assign dec_vec[i] = ret_ev && (retire_dest == ADDR_W'(i));
    assign pending_vec[i] = |cnt[i];

    sb_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .inc   (inc_vec[i]),
      .dec   (dec_vec[i]),
      .cnt   (cnt[i])
    );
  end

  assign src1_hazard = src1_valid && (src1_addr != '0)
                    && (cnt[src1_addr] != '0);
  assign src2_hazard = src2_valid && (src2_addr != '0)
                    && (cnt[src2_addr] != '0);
  assign dest_sat    = dest_check && (issue_dest != '0)
                    && (cnt[issue_dest] == CNT_MAX);

  assign id_ready_go = !(src1_hazard || src2_hazard || dest_sat);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      inflight_cnt <= '0;
    end else if (iss_ev && !ret_ev) begin
      if (inflight_cnt != CNT_MAX)
        inflight_cnt <= inflight_cnt + 1'b1;
    end else if (ret_ev && !iss_ev) begin
      if (inflight_cnt != '0)
        inflight_cnt <= inflight_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed + constrained-random check of rf_scoreboard against
// a per-register counter model feeding an expectation queue.
module tb_rf_scoreboard;

  logic        clk;
  logic        reset;
  logic        issue_fire, issue_we;
  logic [4:0]  issue_dest;
  logic        src1_valid, src2_valid;
  logic [4:0]  src1_addr, src2_addr;
  logic        dest_check;
  logic        retire_fire, retire_we;
  logic [4:0]  retire_dest;
  logic        flush;
  logic        id_ready_go, src1_hazard, src2_hazard;
  logic [31:0] pending_vec;
  logic [1:0]  inflight_cnt;

  int checks = 0;
  int passes = 0;

  int m_cnt [32];
  int m_infl;

  typedef struct {
    string       tag;
    logic [31:0] pend;
    logic [1:0]  infl;
    logic        h1;
    logic        h2;
    logic        rdy;
  } exp_t;

  exp_t exp_q [$];

  rf_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .issue_fire   (issue_fire),
    .issue_we     (issue_we),
    .issue_dest   (issue_dest),
    .src1_valid   (src1_valid),
    .src1_addr    (src1_addr),
    .src2_valid   (src2_valid),
    .src2_addr    (src2_addr),
    .dest_check   (dest_check),
    .retire_fire  (retire_fire),
    .retire_we    (retire_we),
    .retire_dest  (retire_dest),
    .flush        (flush),
    .id_ready_go  (id_ready_go),
    .src1_hazard  (src1_hazard),
    .src2_hazard  (src2_hazard),
    .pending_vec  (pending_vec),
    .inflight_cnt (inflight_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic exp_t model_view(input string tag);
    exp_t e;
    logic sat;
    e.tag  = tag;
    e.pend = '0;
    for (int i = 1; i < 32; i++)
      e.pend[i] = (m_cnt[i] != 0);
    e.infl = 2'(m_infl);
    e.h1   = src1_valid && src1_addr != 0 && m_cnt[src1_addr] != 0;
    e.h2   = src2_valid && src2_addr != 0 && m_cnt[src2_addr] != 0;
    sat    = dest_check && issue_dest != 0 && m_cnt[issue_dest] == 3;
    e.rdy  = !(e.h1 || e.h2 || sat);
    return e;
  endfunction

  task automatic model_update();
    logic ii, rr, same;
    ii   = issue_fire && issue_we;
    rr   = retire_fire && retire_we;
    same = ii && rr && issue_dest == retire_dest;
    if (reset || flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_infl = 0;
    end else begin
      if (ii && issue_dest != 0 && !same && m_cnt[issue_dest] < 3)
        m_cnt[issue_dest]++;
      if (rr && retire_dest != 0 && !same && m_cnt[retire_dest] > 0)
        m_cnt[retire_dest]--;
      if (ii && !rr && m_infl < 3) m_infl++;
      else if (rr && !ii && m_infl > 0) m_infl--;
    end
  endtask

  task automatic compare(input exp_t e);
    chk({e.tag, ".pend"}, pending_vec, e.pend);
    chk({e.tag, ".infl"}, 32'(inflight_cnt), 32'(e.infl));
    chk({e.tag, ".h1"}, 32'(src1_hazard), 32'(e.h1));
    chk({e.tag, ".h2"}, 32'(src2_hazard), 32'(e.h2));
    chk({e.tag, ".rdy"}, 32'(id_ready_go), 32'(e.rdy));
  endtask

  // apply current inputs across one edge, then check the result
  task automatic step(input string tag);
    model_update();
    @(posedge clk);
    #1;
    exp_q.push_back(model_view(tag));
    compare(exp_q.pop_front());
  endtask

  task automatic idle();
    reset       = 1'b0;
    issue_fire  = 1'b0;
    issue_we    = 1'b0;
    issue_dest  = '0;
    src1_valid  = 1'b0;
    src1_addr   = '0;
    src2_valid  = 1'b0;
    src2_addr   = '0;
    dest_check  = 1'b0;
    retire_fire = 1'b0;
    retire_we   = 1'b0;
    retire_dest = '0;
    flush       = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] d);
    issue_fire = 1'b1;
    issue_we   = 1'b1;
    issue_dest = d;
  endtask

  task automatic do_retire(input logic [4:0] d);
    retire_fire = 1'b1;
    retire_we   = 1'b1;
    retire_dest = d;
  endtask

  task automatic no_issue();
    issue_fire = 1'b0;
    issue_we   = 1'b0;
  endtask

  task automatic no_retire();
    retire_fire = 1'b0;
    retire_we   = 1'b0;
  endtask

  initial begin
    int d, r;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_infl = 0;
    idle();

    // reset held two cycles while issuing r5
    reset = 1'b1;
    do_issue(5'd5);
    step("rst0");
    step("rst1");
    chk("rst.pend", pending_vec, 32'h0);
    chk("rst.rdy", 32'(id_ready_go), 32'd1);
    idle();
    step("idle");

    // RAW on r4
    do_issue(5'd4);
    step("raw.iss");
    no_issue();
    src1_valid = 1'b1;
    src1_addr  = 5'd4;
    step("raw.wait");
    chk("raw.h1", 32'(src1_hazard), 32'd1);
    chk("raw.rdy0", 32'(id_ready_go), 32'd0);
    do_retire(5'd4);
    #1;
    chk("raw.same_cyc_h1", 32'(src1_hazard), 32'd1);
    step("raw.ret");
    chk("raw.rdy1", 32'(id_ready_go), 32'd1);
    idle();

    // same-cycle issue+retire of r7
    do_issue(5'd7);
    step("r7.iss");
    do_retire(5'd7);
    step("r7.both");
    chk("r7.pend", 32'(pending_vec[7]), 32'd1);
    chk("r7.infl", 32'(inflight_cnt), 32'd1);
    no_issue();
    step("r7.ret");
    idle();

    // different registers in the same cycle
    do_issue(5'd5);
    step("r5.iss");
    do_issue(5'd6);
    do_retire(5'd5);
    step("r5r6.both");
    chk("r5r6.pend", pending_vec, 32'h0000_0040);
    no_issue();
    retire_dest = 5'd6;
    step("r6.ret");
    idle();

    // r0 is never tracked
    do_issue(5'd0);
    step("r0.iss");
    no_issue();
    src2_valid = 1'b1;
    src2_addr  = 5'd0;
    step("r0.read");
    chk("r0.h2", 32'(src2_hazard), 32'd0);
    chk("r0.pend", pending_vec, 32'h0);
    do_retire(5'd0);
    step("r0.ret");
    idle();

    // saturation on r9
    do_issue(5'd9);
    step("sat.1");
    step("sat.2");
    step("sat.3");
    no_issue();
    dest_check = 1'b1;
    step("sat.chk");
    chk("sat.rdy0", 32'(id_ready_go), 32'd0);
    chk("sat.infl", 32'(inflight_cnt), 32'd3);
    do_retire(5'd9);
    step("sat.ret1");
    chk("sat.rdy1", 32'(id_ready_go), 32'd1);
    dest_check = 1'b0;
    step("sat.ret2");
    step("sat.ret3");
    idle();

    // flush beats a same-cycle issue
    do_issue(5'd3);
    step("fl.r3");
    do_issue(5'd12);
    step("fl.r12");
    do_issue(5'd20);
    flush = 1'b1;
    step("fl.go");
    chk("fl.pend", pending_vec, 32'h0);
    chk("fl.infl", 32'(inflight_cnt), 32'd0);
    idle();

    // mid-operation reset
    do_issue(5'd15);
    step("mr.iss");
    no_issue();
    reset = 1'b1;
    step("mr.rst");
    chk("mr.pend", pending_vec, 32'h0);
    idle();
    step("mr.idle");

    // constrained random traffic on r0..r7
    for (int n = 0; n < 200; n++) begin
      idle();
      d = int'($urandom_range(0, 7));
      r = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1 && m_cnt[d] < 3)
        do_issue(5'(d));
      if ($urandom_range(0, 1) == 1 && (m_cnt[r] > 0 || r == 0))
        do_retire(5'(r));
      src1_valid = 1'($urandom_range(0, 1));
      src1_addr  = 5'($urandom_range(0, 7));
      src2_valid = 1'($urandom_range(0, 1));
      src2_addr  = 5'($urandom_range(0, 7));
      dest_check = 1'($urandom_range(0, 1));
      if (!issue_fire) issue_dest = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 19) == 0);
      step("rnd");
    end
    idle();
    flush = 1'b1;
    step("end.flush");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
